// File: rtl/lane_skid_stage.sv
// Lane-masking ready/valid stage: two-entry skid (SLICE_MODE 0) or single register (SLICE_MODE 1).
// Define LANE_SKID_COUNT_EN to add the o_count transfer counter port.

module lane_skid_lane #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] lane_in,
  input  logic              lane_en,
  output logic [LANE_W-1:0] lane_out
);
  assign lane_out = lane_en ? lane_in : '0;
endmodule

module lane_skid_stage #(
  parameter int LANES      = 4,
  parameter int LANE_W     = 8,
  parameter int SLICE_MODE = 0,
  parameter int CNT_W      = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [LANES*LANE_W-1:0] i_data,
  input  logic [LANES-1:0]        i_mask,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [LANES*LANE_W-1:0] o_data,
  output logic [LANES-1:0]        o_mask
`ifdef LANE_SKID_COUNT_EN
  ,
  output logic [CNT_W-1:0]        o_count
`endif
);

  typedef struct packed {
    logic [LANES-1:0][LANE_W-1:0] data;
    logic [LANES-1:0]             mask;
  } word_t;

  logic [LANES-1:0][LANE_W-1:0] lane_in, lane_m;
  word_t cap_w, out_w;
  logic  in_xfer, out_xfer;

  if (LANES < 1) begin : g_bad_lanes
    $error("lane_skid_stage: LANES must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("lane_skid_stage: CNT_W must be at least 1");
  end

  assign lane_in = i_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_skid_lane #(.LANE_W(LANE_W)) u_lane (
      .lane_in (lane_in[k]),
      .lane_en (i_mask[k]),
      .lane_out(lane_m[k])
    );
  end

  assign cap_w.data = lane_m;
  assign cap_w.mask = i_mask;

  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;

  case (SLICE_MODE)
    0: begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
      state_t state_q, state_d;
      word_t  out_q, skid_q;
      logic   rdy_q;
      logic   load_out, load_skid, pop_skid;

      always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state_q)
          EMPTY: if (in_xfer) begin
            state_d  = ONE;
            load_out = 1'b1;
          end
          ONE: begin
            if (in_xfer && !out_xfer) begin
              state_d   = FULL;
              load_skid = 1'b1;
            end else if (in_xfer && out_xfer) begin
              load_out = 1'b1;
            end else if (out_xfer) begin
              state_d = EMPTY;
            end
          end
          FULL: if (out_xfer) begin
            state_d  = ONE;
            pop_skid = 1'b1;
          end
          default: state_d = EMPTY;
        endcase
      end

      // Ready is registered from the next state so i_ready never reaches o_ready combinationally.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_q <= EMPTY;
          rdy_q   <= 1'b1;
          out_q   <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          rdy_q   <= (state_d != FULL);
          if (load_out)      out_q <= cap_w;
          else if (pop_skid) out_q <= skid_q;
          if (load_skid)     skid_q <= cap_w;
        end
      end

      assign o_ready = rdy_q;
      assign o_valid = (state_q != EMPTY);
      assign out_w   = out_q;
    end
    1: begin : g_reg
      word_t out_q;
      logic  vld_q, rdy_q;

      // rdy_q is kept as the complement of vld_q so o_ready comes straight off a flop.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
          out_q <= '0;
        end else if (in_xfer) begin
          vld_q <= 1'b1;
          rdy_q <= 1'b0;
          out_q <= cap_w;
        end else if (out_xfer) begin
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
        end
      end

      assign o_ready = rdy_q;
      assign o_valid = vld_q;
      assign out_w   = out_q;
    end
    default: begin : g_bad_mode
      $error("lane_skid_stage: SLICE_MODE must be 0 or 1");
    end
  endcase

  assign o_data = out_w.data;
  assign o_mask = out_w.mask;

`ifdef LANE_SKID_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)         cnt_q <= '0;
    else if (out_xfer) cnt_q <= cnt_q + 1'b1;
  end

  assign o_count = cnt_q;
`endif

endmodule

// File: tb/tb_lane_skid_stage.sv
// Bench for lane_skid_stage: mode 0 (CNT_W=4) and mode 1 instances against a queue-based model.
// Counter checks are active when LANE_SKID_COUNT_EN is defined.

module tb_lane_skid_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_ready, a_ovalid, a_iready = 1'b0;
  logic [31:0] a_data = '0, a_odata;
  logic [3:0]  a_mask = '0, a_omask;
  logic [3:0]  a_count;
  logic        b_valid = 1'b0, b_ready, b_ovalid, b_iready = 1'b0;
  logic [31:0] b_data = '0, b_odata;
  logic [3:0]  b_mask = '0, b_omask;
  logic [15:0] b_count;

  int checks = 0;
  int failures = 0;

  lane_skid_stage #(.LANES(4), .LANE_W(8), .SLICE_MODE(0), .CNT_W(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready),
    .i_data(a_data), .i_mask(a_mask), .o_valid(a_ovalid), .i_ready(a_iready),
`ifdef LANE_SKID_COUNT_EN
    .o_count(a_count),
`endif
    .o_data(a_odata), .o_mask(a_omask)
  );

  lane_skid_stage #(.LANES(4), .LANE_W(8), .SLICE_MODE(1), .CNT_W(16)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_data(b_data), .i_mask(b_mask), .o_valid(b_ovalid), .i_ready(b_iready),
`ifdef LANE_SKID_COUNT_EN
    .o_count(b_count),
`endif
    .o_data(b_odata), .o_mask(b_omask)
  );

`ifndef LANE_SKID_COUNT_EN
  assign a_count = '0;
  assign b_count = '0;
`endif

  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) if (m[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  // Reference model: each stage is a FIFO of {mask, masked data}; mode 0 holds 2, mode 1 holds 1.
  logic [35:0] qa[$];
  logic [35:0] qb[$];
  int cnt_a = 0;
  int cnt_b = 0;

  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      cnt_a <= 0;
      cnt_b <= 0;
    end else begin
      if (a_valid && qa.size() < 2) begin
        if (qa.size() > 0 && a_iready) begin
          void'(qa.pop_front());
          cnt_a <= (cnt_a + 1) % 16;
        end
        qa.push_back({a_mask, mask_word(a_data, a_mask)});
      end else if (qa.size() > 0 && a_iready) begin
        void'(qa.pop_front());
        cnt_a <= (cnt_a + 1) % 16;
      end
      if (qb.size() == 0) begin
        if (b_valid) qb.push_back({b_mask, mask_word(b_data, b_mask)});
      end else if (b_iready) begin
        void'(qb.pop_front());
        cnt_b <= (cnt_b + 1) % 65536;
      end
    end
  end

  task automatic idle(input int n);
    a_valid = 1'b0; b_valid = 1'b0;
    a_iready = 1'b1; b_iready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_data = 32'h12345678; b_data = 32'h9abcdef0; a_mask = 4'hf; b_mask = 4'hf;
    @(negedge clk);
    @(negedge clk);
    checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b exp=0", a_ovalid); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
    checks++; if (a_odata !== 32'h0 || a_omask !== 4'h0) begin failures++; $display("FAIL reset_a_data got=%h/%h exp=0/0", a_odata, a_omask); end
    checks++; if (b_ovalid !== 1'b0 || b_ready !== 1'b1) begin failures++; $display("FAIL reset_b_vr got=%b%b exp=01", b_ovalid, b_ready); end
    checks++; if (b_odata !== 32'h0 || b_omask !== 4'h0) begin failures++; $display("FAIL reset_b_data got=%h/%h exp=0/0", b_odata, b_omask); end
`ifdef LANE_SKID_COUNT_EN
    checks++; if (a_count !== 4'd0 || b_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0/0", a_count, b_count); end
`endif
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_mask();
    idle(2);
    a_valid = 1'b1; a_data = 32'hAABBCCDD; a_mask = 4'b0101;
    @(negedge clk);
    a_valid = 1'b0;
    checks++; if (a_ovalid !== 1'b1) begin failures++; $display("FAIL mask_valid got=%b exp=1", a_ovalid); end
    checks++; if (a_odata !== 32'h00BB00DD) begin failures++; $display("FAIL mask_data got=%h exp=00bb00dd", a_odata); end
    checks++; if (a_omask !== 4'b0101) begin failures++; $display("FAIL mask_mask got=%b exp=0101", a_omask); end
  endtask

  task automatic test_streaming();
    idle(2);
    for (int i = 0; i <= 8; i++) begin
      checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=1", i, a_ready); end
      if (i > 0) begin
        checks++;
        if (a_ovalid !== 1'b1 || a_odata !== 32'(i - 1)) begin
          failures++; $display("FAIL stream_data cyc=%0d got=%b/%h exp=1/%h", i, a_ovalid, a_odata, 32'(i - 1));
        end
      end
      a_valid = (i < 8); a_data = 32'(i); a_mask = 4'hf;
      @(negedge clk);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    idle(2);
    a_iready = 1'b0; a_mask = 4'hf;
    a_valid = 1'b1; a_data = 32'd1;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1 || a_odata !== 32'd1) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/1", a_ready, a_odata); end
    a_data = 32'd2;
    @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", a_ready); end
    a_data = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_ready !== 1'b0 || a_ovalid !== 1'b1 || a_odata !== 32'd1) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b%b/%h exp=01/1", i, a_ready, a_ovalid, a_odata);
      end
    end
    a_iready = 1'b1;
    @(negedge clk);
    checks++; if (a_odata !== 32'd2 || a_ready !== 1'b1) begin failures++; $display("FAIL bp_out2 got=%h/%b exp=2/1", a_odata, a_ready); end
    @(negedge clk);
    checks++; if (a_odata !== 32'd3 || a_ovalid !== 1'b1) begin failures++; $display("FAIL bp_out3 got=%h/%b exp=3/1", a_odata, a_ovalid); end
    a_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", a_ovalid); end
  endtask

  task automatic test_half_throughput();
    logic [31:0] last;
    int nx;
    idle(2);
    nx = 0; last = '0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (b_ready !== (i % 2 == 0)) begin failures++; $display("FAIL half_ready cyc=%0d got=%b exp=%b", i, b_ready, (i % 2 == 0)); end
      if (b_ovalid && b_iready) begin
        nx++;
        checks++; if (b_odata !== last) begin failures++; $display("FAIL half_data cyc=%0d got=%h exp=%h", i, b_odata, last); end
      end
      b_valid = 1'b1;
      if (b_ready) begin
        b_data = $urandom; b_mask = 4'($urandom);
        last = mask_word(b_data, b_mask);
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    checks++; if (nx != 5) begin failures++; $display("FAIL half_count got=%0d exp=5", nx); end
  endtask

  task automatic test_count_wrap();
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_iready = 1'b1; a_mask = 4'hf;
    for (int i = 0; i < 17; i++) begin
      a_valid = 1'b1; a_data = 32'(i);
      @(negedge clk);
    end
    a_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%b exp=0", a_ovalid); end
`ifdef LANE_SKID_COUNT_EN
    checks++; if (a_count !== 4'd1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", a_count); end
`endif
    a_iready = 1'b0; a_valid = 1'b1; a_data = 32'h55;
    @(negedge clk);
    a_data = 32'h66;
    @(negedge clk);
    a_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (a_ovalid !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL midrst_vr got=%b%b exp=01", a_ovalid, a_ready); end
`ifdef LANE_SKID_COUNT_EN
    checks++; if (a_count !== 4'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", a_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++; if (a_ovalid !== (qa.size() > 0) || a_ready !== (qa.size() < 2)) begin
        failures++; $display("FAIL rand_a_vr cyc=%0d got=%b%b exp=%b%b", i, a_ovalid, a_ready, qa.size() > 0, qa.size() < 2);
      end
      if (qa.size() > 0) begin
        checks++; if ({a_omask, a_odata} !== qa[0]) begin failures++; $display("FAIL rand_a_data cyc=%0d got=%h exp=%h", i, {a_omask, a_odata}, qa[0]); end
      end
      checks++; if (b_ovalid !== (qb.size() > 0) || b_ready !== (qb.size() == 0)) begin
        failures++; $display("FAIL rand_b_vr cyc=%0d got=%b%b exp=%b%b", i, b_ovalid, b_ready, qb.size() > 0, qb.size() == 0);
      end
      if (qb.size() > 0) begin
        checks++; if ({b_omask, b_odata} !== qb[0]) begin failures++; $display("FAIL rand_b_data cyc=%0d got=%h exp=%h", i, {b_omask, b_odata}, qb[0]); end
      end
`ifdef LANE_SKID_COUNT_EN
      checks++; if (a_count !== 4'(cnt_a) || b_count !== 16'(cnt_b)) begin
        failures++; $display("FAIL rand_count cyc=%0d got=%0d/%0d exp=%0d/%0d", i, a_count, b_count, cnt_a, cnt_b);
      end
`endif
      a_valid = ($urandom_range(0, 3) != 0); a_iready = ($urandom_range(0, 2) != 0);
      a_data = $urandom; a_mask = 4'($urandom);
      b_valid = ($urandom_range(0, 3) != 0); b_iready = ($urandom_range(0, 2) != 0);
      b_data = $urandom; b_mask = 4'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_streaming();
    test_back_pressure();
    test_half_throughput();
    test_count_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_skid_stage.md
# lane_skid_stage

Registered ready/valid stage that sits directly downstream of the generate-selected lane assignment logic. It takes a multi-lane data word plus a per-lane enable mask, zeroes disabled lanes, and presents the word to the next consumer through a skid buffer so that back-pressure never combinationally reaches the producer. A generate-time mode selects either a full-throughput two-entry skid or a half-throughput single register.

## Interface

Parameters:
- LANES, 4: number of lanes; must be at least 1.
- LANE_W, 8: bits per lane.
- SLICE_MODE, 0: 0 selects the full-throughput two-entry skid; 1 selects the half-throughput single register. Any other value is a compile-time error raised from the `default` branch of a generate case.
- CNT_W, 16: width of the transfer counter. Only used when LANE_SKID_COUNT_EN is defined.

Ports:
- i_clk, input, 1: the single clock.
- i_rst, input, 1: reset, synchronous and active-high.
- i_valid, input, 1: upstream word valid.
- o_ready, output, 1: stage can accept a word. Driven directly from a flop.
- i_data, input, LANES*LANE_W: upstream word. Lane k occupies bits [k*LANE_W +: LANE_W].
- i_mask, input, LANES: per-lane enable. 1 means lane k is passed; 0 means lane k is forced to zero.
- o_valid, output, 1: downstream word valid.
- i_ready, input, 1: downstream accepts.
- o_data, output, LANES*LANE_W: masked word.
- o_mask, output, LANES: mask that travels with the word.
- o_count, output, CNT_W: count of completed downstream transfers. Present only when LANE_SKID_COUNT_EN is defined.

## Operation

- Accept handshake: an input transfer happens on a cycle where i_valid && o_ready. An output transfer happens on a cycle where o_valid && i_ready.
- Masking:
  - Applied at capture, one generate-for iteration per lane.
  - Stored lane k = i_mask[k] ? i_data lane k : 0.
  - o_mask equals the captured i_mask.
- SLICE_MODE 0 uses a two-entry skid with states EMPTY, ONE and FULL:
  - EMPTY, input transfer: capture into the output register, go to ONE.
  - ONE, input transfer with no output transfer: capture into the skid register, go to FULL.
  - ONE, input and output transfer together: the output register reloads from the input, stay in ONE.
  - ONE, output transfer only: go to EMPTY.
  - FULL, output transfer: the skid register moves into the output register, go to ONE. No input is accepted in FULL.
  - o_ready = (state != FULL), registered.
  - o_valid = (state != EMPTY).
- SLICE_MODE 1 uses a single register:
  - o_ready = !o_valid.
  - Input transfer: capture and set o_valid.
  - Output transfer: clear o_valid.
  - An input and an output transfer can never fall in the same cycle, so sustained throughput is at most 1 word per 2 cycles.
- Data ordering: words leave in the order they were accepted. None are dropped or duplicated.
- Holding: o_data and o_mask stay stable while o_valid && !i_ready.
- Inputs while not accepting: i_data and i_mask are ignored whenever no input transfer occurs.

## Timing

- Reset values: while i_rst is high at a rising i_clk edge, the next cycle shows:
  - state = EMPTY
  - o_valid = 0, o_ready = 1
  - o_data = 0, o_mask = 0
  - o_count = 0
- Reset mid-operation discards all held words. No output transfer is reported in the cycle after reset.
- Latency: an accepted word appears on o_valid/o_data on the next cycle in both modes.
- Throughput:
  - Mode 0 with i_ready held at 1 sustains 1 word per cycle.
  - Mode 1 sustains 1 word per 2 cycles.
- Back-pressure: in mode 0, o_ready falls the cycle after the second unconsumed word is accepted. This happens because the registered o_ready absorbs the one-cycle skid.
- No combinational path runs from i_ready to o_ready, or from i_valid to o_valid.

## Configuration

- LANE_SKID_COUNT_EN defined:
  - o_count exists.
  - It increments by 1 on every output transfer.
  - It wraps modulo 2^CNT_W, so the maximum value goes to 0.
  - Reset clears it to 0.
- LANE_SKID_COUNT_EN undefined:
  - No o_count port and no counter logic.
  - All other behaviour is identical.

## Test plan

All scenarios use LANES=4 and LANE_W=8.

- Reset: assert i_rst for 2 cycles while i_valid=1. Afterwards expect o_valid=0, o_ready=1, o_data=0 and, with the macro on, o_count=0.
- Mask: in mode 0, drive i_data=0xAABBCCDD, i_mask=4'b0101, i_ready=1.
  - Next cycle: o_data=0x00BB00DD, o_mask=4'b0101, o_valid=1.
- Streaming: in mode 0, with i_ready=1, send 8 consecutive words 0..7 on 8 cycles.
  - Outputs 0..7 appear on 8 consecutive cycles.
  - o_ready stays 1 throughout.
- Back-pressure: in mode 0, hold i_ready=0 and offer words 1, 2, 3.
  - Words 1 and 2 are accepted, then o_ready=0.
  - Word 3 is held by the upstream producer.
  - Raise i_ready: outputs come out as 1, 2, 3 in order, with o_data held stable while stalled.
- Half-throughput: in mode 1, with i_valid=1 and i_ready=1 continuously for 10 cycles.
  - Exactly 5 output transfers occur.
  - o_ready alternates 1, 0.
- Counter wrap: with the macro on and CNT_W=4, run 17 transfers.
  - o_count reads 1.
  - Assert i_rst mid-stream: o_count=0 and o_valid=0 the next cycle.
